// File: rtl/iicmb_cmd_seq_pkg.sv
// Shared constants and types for the IICMB command sequencer: register map,
// command codes, CMDR status bits and the sequencer state/phase encodings.
package iicmb_cmd_seq_pkg;

  localparam int unsigned AdrCsr  = 0;
  localparam int unsigned AdrDpr  = 1;
  localparam int unsigned AdrCmdr = 2;

  localparam logic [2:0] CmdWrite   = 3'b001;
  localparam logic [2:0] CmdReadAck = 3'b010;
  localparam logic [2:0] CmdReadNak = 3'b011;
  localparam logic [2:0] CmdStart   = 3'b100;
  localparam logic [2:0] CmdStop    = 3'b101;
  localparam logic [2:0] CmdSetBus  = 3'b110;

  localparam int unsigned CmdrDon = 7;
  localparam int unsigned CmdrNak = 6;
  localparam int unsigned CmdrAl  = 5;
  localparam int unsigned CmdrErr = 4;

  // Core enable plus interrupt enable.
  localparam logic [7:0] CsrEnable = 8'hC0;

  typedef enum logic [2:0] {
    StInit, StIdle, StSetbus, StStart, StAddr, StData, StStop, StFin
  } state_t;

  typedef enum logic {OpWrite = 1'b0, OpRead = 1'b1} op_t;

  // Micro-steps inside a state: register writes, interrupt wait, status/data reads.
  typedef enum logic [3:0] {
    PhWdat, PhDpr, PhDprW, PhCmd, PhCmdW, PhIrq, PhStat, PhStatW, PhRd, PhRdW
  } phase_t;

  function automatic phase_t entry_phase(state_t st, op_t op);
    phase_t ph;
    case (st)
      StSetbus, StAddr: ph = PhDpr;
      StData:           ph = (op == OpWrite) ? PhWdat : PhCmd;
      default:          ph = PhCmd;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/iicmb_cmd_seq_if.sv
// Wishbone master bus toward the IICMB core, including its interrupt line.
interface iicmb_cmd_seq_if #(
  parameter int unsigned WB_ADDR_WIDTH = 2,
  parameter int unsigned WB_DATA_WIDTH = 8
);
  logic                     cyc_o;
  logic                     stb_o;
  logic                     we_o;
  logic [WB_ADDR_WIDTH-1:0] adr_o;
  logic [WB_DATA_WIDTH-1:0] dat_o;
  logic [WB_DATA_WIDTH-1:0] dat_i;
  logic                     ack_i;
  logic                     irq_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, irq_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, irq_i
  );
endinterface

// File: rtl/iicmb_wb_xfer.sv
// Single-access Wishbone engine: one registered cycle per start, done pulses
// the cycle after ack with read data already captured.
module iicmb_wb_xfer #(
  parameter int unsigned WB_ADDR_WIDTH = 2,
  parameter int unsigned WB_DATA_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start,
  input  logic                     we,
  input  logic [WB_ADDR_WIDTH-1:0] adr,
  input  logic [WB_DATA_WIDTH-1:0] wdata,
  output logic                     busy,
  output logic                     done,
  output logic [WB_DATA_WIDTH-1:0] rdata,
  iicmb_cmd_seq_if.master          wb
);

  logic                     cyc_q;
  logic                     we_q;
  logic [WB_ADDR_WIDTH-1:0] adr_q;
  logic [WB_DATA_WIDTH-1:0] dat_q;
  logic                     done_q;
  logic [WB_DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        // ack outside an owned cycle never reaches this branch.
        if (wb.ack_i) begin
          cyc_q  <= 1'b0;
          we_q   <= 1'b0;
          adr_q  <= '0;
          dat_q  <= '0;
          done_q <= 1'b1;
          if (!we_q) rdata_q <= wb.dat_i;
        end
      end else if (start) begin
        cyc_q <= 1'b1;
        we_q  <= we;
        adr_q <= adr;
        dat_q <= we ? wdata : '0;
      end
    end
  end

  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = cyc_q;
  assign wb.we_o  = we_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign busy     = cyc_q;
  assign done     = done_q;
  assign rdata    = rdata_q;

endmodule

// File: rtl/iicmb_cmd_seq.sv
// Drives an IICMB core over Wishbone to run whole I2C read/write transactions
// from a simple request port, reporting NAK/arbitration status at the end.
module iicmb_cmd_seq
  import iicmb_cmd_seq_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH  = 2,
  parameter int unsigned WB_DATA_WIDTH  = 8,
  parameter int unsigned I2C_ADDR_WIDTH = 7,
  parameter int unsigned BUS_ID         = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_rd_i,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [4:0]                req_len_i,
  input  logic [7:0]                wdata_i,
  input  logic                      wdata_valid_i,
  output logic                      wdata_ready_o,
  output logic [7:0]                rdata_o,
  output logic                      rdata_valid_o,
  output logic                      done_o,
  output logic                      nak_o,
  output logic                      err_o,
  iicmb_cmd_seq_if.master           wb
);

  state_t                    state_q, state_d;
  phase_t                    phase_q, phase_d;
  op_t                       op_q, op_d;
  logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [7:0]                byte_q, byte_d;
  logic                      nak_q, nak_d;
  logic                      err_q, err_d;

  logic                     xfer_start, xfer_we, xfer_busy, xfer_done;
  logic [WB_ADDR_WIDTH-1:0] xfer_adr;
  logic [WB_DATA_WIDTH-1:0] xfer_wdata, xfer_rdata;
  logic [7:0]               status, dpr_val;
  logic [2:0]               cmd;
  logic                     last;

  iicmb_wb_xfer #(
    .WB_ADDR_WIDTH(WB_ADDR_WIDTH),
    .WB_DATA_WIDTH(WB_DATA_WIDTH)
  ) u_xfer (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .start  (xfer_start),
    .we     (xfer_we),
    .adr    (xfer_adr),
    .wdata  (xfer_wdata),
    .busy   (xfer_busy),
    .done   (xfer_done),
    .rdata  (xfer_rdata),
    .wb     (wb)
  );

  assign status        = 8'(xfer_rdata);
  assign last          = (cnt_q == 5'd1);
  assign rdata_o       = 8'(xfer_rdata);
  assign req_ready_o   = (state_q == StIdle);
  assign done_o        = (state_q == StFin);
  assign nak_o         = done_o & nak_q;
  assign err_o         = done_o & err_q;

  always_comb begin
    cmd     = CmdStop;
    dpr_val = 8'(BUS_ID);
    case (state_q)
      StSetbus: cmd = CmdSetBus;
      StStart:  cmd = CmdStart;
      StAddr: begin
        cmd     = CmdWrite;
        dpr_val = 8'({addr_q, op_q});
      end
      StData: begin
        cmd     = (op_q == OpWrite) ? CmdWrite : (last ? CmdReadNak : CmdReadAck);
        dpr_val = byte_q;
      end
      default: cmd = CmdStop;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    op_d          = op_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    byte_d        = byte_q;
    nak_d         = nak_q;
    err_d         = err_q;
    xfer_start    = 1'b0;
    xfer_we       = 1'b1;
    xfer_adr      = WB_ADDR_WIDTH'(AdrCmdr);
    xfer_wdata    = '0;
    wdata_ready_o = 1'b0;
    rdata_valid_o = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d    = op_t'(req_rd_i);
          addr_d  = req_addr_i;
          cnt_d   = (req_len_i == 5'd0) ? 5'd1 : req_len_i;
          nak_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StSetbus;
          phase_d = entry_phase(StSetbus, op_t'(req_rd_i));
        end
      end
      StFin: state_d = StIdle;
      default: begin
        case (phase_q)
          PhWdat: begin
            if (wdata_valid_i) begin
              wdata_ready_o = 1'b1;
              byte_d        = wdata_i;
              phase_d       = PhDpr;
            end
          end
          PhDpr: begin
            xfer_start = 1'b1;
            xfer_adr   = WB_ADDR_WIDTH'(AdrDpr);
            xfer_wdata = WB_DATA_WIDTH'(dpr_val);
            if (!xfer_busy) phase_d = PhDprW;
          end
          PhDprW: if (xfer_done) phase_d = PhCmd;
          PhCmd: begin
            xfer_start = 1'b1;
            if (state_q == StInit) begin
              xfer_adr   = WB_ADDR_WIDTH'(AdrCsr);
              xfer_wdata = WB_DATA_WIDTH'(CsrEnable);
            end else begin
              xfer_wdata = WB_DATA_WIDTH'(cmd);
            end
            if (!xfer_busy) phase_d = PhCmdW;
          end
          PhCmdW: begin
            if (xfer_done) begin
              if (state_q == StInit) state_d = StIdle;
              else                   phase_d = PhIrq;
            end
          end
          PhIrq: if (wb.irq_i) phase_d = PhStat;
          PhStat: begin
            xfer_start = 1'b1;
            xfer_we    = 1'b0;
            if (!xfer_busy) phase_d = PhStatW;
          end
          PhStatW: begin
            if (xfer_done) begin
              if (status[CmdrAl] || status[CmdrErr]) begin
                err_d   = 1'b1;
                state_d = StFin;
              end else if (status[CmdrNak] && (state_q == StAddr || state_q == StData)) begin
                nak_d   = 1'b1;
                state_d = StStop;
                phase_d = entry_phase(StStop, op_q);
              end else begin
                case (state_q)
                  StSetbus: begin
                    state_d = StStart;
                    phase_d = entry_phase(StStart, op_q);
                  end
                  StStart: begin
                    state_d = StAddr;
                    phase_d = entry_phase(StAddr, op_q);
                  end
                  StAddr: begin
                    state_d = StData;
                    phase_d = entry_phase(StData, op_q);
                  end
                  StData: begin
                    if (op_q == OpRead) begin
                      phase_d = PhRd;
                    end else if (last) begin
                      state_d = StStop;
                      phase_d = entry_phase(StStop, op_q);
                    end else begin
                      cnt_d   = cnt_q - 5'd1;
                      phase_d = entry_phase(StData, op_q);
                    end
                  end
                  default: state_d = StFin;
                endcase
              end
            end
          end
          PhRd: begin
            xfer_start = 1'b1;
            xfer_we    = 1'b0;
            xfer_adr   = WB_ADDR_WIDTH'(AdrDpr);
            if (!xfer_busy) phase_d = PhRdW;
          end
          PhRdW: begin
            if (xfer_done) begin
              rdata_valid_o = 1'b1;
              if (last) begin
                state_d = StStop;
                phase_d = entry_phase(StStop, op_q);
              end else begin
                cnt_d   = cnt_q - 5'd1;
                phase_d = PhCmd;
              end
            end
          end
          default: phase_d = PhCmd;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StInit;
      phase_q <= PhCmd;
      op_q    <= OpWrite;
      addr_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      nak_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      nak_q   <= nak_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_iicmb_cmd_seq.sv
// Directed bench: an IICMB slave model answers Wishbone accesses while a
// transaction-level model predicts the access list, read bytes and status.
module tb_iicmb_cmd_seq;

  localparam int unsigned BusId = 3;

  typedef struct packed {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
  } acc_t;

  logic       clk, rst_n;
  logic       req_valid, req_ready, req_rd;
  logic [6:0] req_addr;
  logic [4:0] req_len;
  logic [7:0] wdata, rdata;
  logic       wdata_valid, wdata_ready, rdata_valid, done, nak, err;

  iicmb_cmd_seq_if #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) bus ();

  iicmb_cmd_seq #(
    .WB_ADDR_WIDTH (2),
    .WB_DATA_WIDTH (8),
    .I2C_ADDR_WIDTH(7),
    .BUS_ID        (BusId)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_rd_i     (req_rd),
    .req_addr_i   (req_addr),
    .req_len_i    (req_len),
    .wdata_i      (wdata),
    .wdata_valid_i(wdata_valid),
    .wdata_ready_o(wdata_ready),
    .rdata_o      (rdata),
    .rdata_valid_o(rdata_valid),
    .done_o       (done),
    .nak_o        (nak),
    .err_o        (err),
    .wb           (bus)
  );

  int checks = 0, failures = 0;
  int acc_seen = 0, done_cnt = 0, wr_pulses = 0;
  acc_t       exp_q[$];
  logic [7:0] exp_rdata[$];
  bit         exp_nak, exp_err;
  logic [7:0] tx_b[8];
  logic [7:0] lit_w[10], lit_r[10];

  // Slave configuration and state.
  bit         cfg_nak_addr, cfg_al_start, pend;
  int         irq_cnt = 0, wr_since_start = 0, sl_idx = 0;
  logic [7:0] status = 8'h80;
  logic [10:0] snap;
  logic [2:0] cmd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push(input bit we, input logic [1:0] adr, input logic [7:0] d);
    acc_t a;
    a.we  = we;
    a.adr = adr;
    a.dat = d;
    exp_q.push_back(a);
  endfunction

  // Transaction-level expectation: every register access the core must see.
  function automatic void model_txn(input bit rd, input logic [6:0] a, input int len,
                                    input bit nak_a, input bit al_s);
    int n = (len == 0) ? 1 : len;
    exp_nak = 1'b0;
    exp_err = 1'b0;
    push(1, 2'd1, 8'(BusId)); push(1, 2'd2, 8'h06); push(0, 2'd2, 8'h00);
    push(1, 2'd2, 8'h04);     push(0, 2'd2, 8'h00);
    if (al_s) begin
      exp_err = 1'b1;
      return;
    end
    push(1, 2'd1, {a, rd}); push(1, 2'd2, 8'h01); push(0, 2'd2, 8'h00);
    if (!nak_a) begin
      for (int i = 0; i < n; i++) begin
        if (!rd) begin
          push(1, 2'd1, tx_b[i]); push(1, 2'd2, 8'h01); push(0, 2'd2, 8'h00);
        end else begin
          push(1, 2'd2, (i == n - 1) ? 8'h03 : 8'h02); push(0, 2'd2, 8'h00);
          push(0, 2'd1, 8'h00);
          exp_rdata.push_back(tx_b[i]);
        end
      end
    end
    push(1, 2'd2, 8'h05); push(0, 2'd2, 8'h00);
    exp_nak = nak_a;
  endfunction

  task automatic pin_model(input string name, input logic [7:0] lit[10], input int n);
    int k = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i].we) begin
        if (k < n) chk(name, exp_q[i].dat, lit[k]);
        k++;
      end
    end
    chk({name, "_count"}, k, n);
  endtask

  // Slave: one wait state, ack for one cycle, irq three cycles after a command.
  initial begin
    bus.ack_i = 1'b0;
    bus.dat_i = 8'h00;
    bus.irq_i = 1'b0;
    pend      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.ack_i = 1'b0; bus.irq_i = 1'b0; irq_cnt = 0; pend = 1'b0; wr_since_start = 0;
        continue;
      end
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) bus.irq_i = 1'b1;
      end
      if (bus.ack_i) begin
        bus.ack_i = 1'b0;
        pend      = 1'b0;
        if (snap[10] && snap[9:8] == 2'd2) begin
          cmd    = snap[2:0];
          status = 8'h80;
          if (cmd == 3'b100) begin
            wr_since_start = 0;
            if (cfg_al_start) status = 8'h20;
          end
          if (cmd == 3'b001) begin
            if (wr_since_start == 0 && cfg_nak_addr) status = 8'hC0;
            wr_since_start++;
          end
          irq_cnt = 3;
        end else if (!snap[10] && snap[9:8] == 2'd2) begin
          bus.irq_i = 1'b0;
        end
      end else if (bus.cyc_o && bus.stb_o) begin
        if (!pend) begin
          pend = 1'b1;
          snap = {bus.we_o, bus.adr_o, bus.dat_o};
        end else begin
          chk("wb_stable", {bus.we_o, bus.adr_o, bus.dat_o}, snap);
          bus.ack_i = 1'b1;
          if (!bus.we_o) begin
            if (bus.adr_o == 2'd2) begin
              bus.dat_i = status;
            end else begin
              bus.dat_i = tx_b[sl_idx % 8];
              sl_idx++;
            end
          end
        end
      end
    end
  end

  // Compare process against the transaction model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cyc_o && bus.stb_o && bus.ack_i) begin
        acc_t e;
        acc_seen++;
        chk("wb_access_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wb_we", bus.we_o, e.we);
          chk("wb_adr", bus.adr_o, e.adr);
          if (e.we) chk("wb_dat", bus.dat_o, e.dat);
        end
      end
      if (rdata_valid) begin
        chk("rdata_expected", exp_rdata.size() > 0, 1);
        if (exp_rdata.size() > 0) chk("rdata", rdata, exp_rdata.pop_front());
      end
      if (wdata_ready) wr_pulses++;
      if (done) begin
        done_cnt++;
        chk("done_nak", nak, exp_nak);
        chk("done_err", err, exp_err);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 500);
    if (!req_ready) chk("ready_timeout", req_ready, 1);
  endtask

  task automatic drive_req(input bit rd, input logic [6:0] a, input logic [4:0] len);
    wait_ready();
    req_valid   = 1'b1;
    req_rd      = rd;
    req_addr    = a;
    req_len     = len;
    wdata       = tx_b[0];
    wdata_valid = !rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input bit rd, input logic [6:0] a, input logic [4:0] len,
                         input bit nak_a, input bit al_s);
    int  n   = (len == 0) ? 1 : int'(len);
    int  idx = 0, cyc = 0;
    int  d0  = done_cnt, w0 = wr_pulses;
    bit  took;
    cfg_nak_addr = nak_a;
    cfg_al_start = al_s;
    sl_idx       = 0;
    drive_req(rd, a, len);
    forever begin
      @(negedge clk);
      took = wdata_ready;
      if (done) break;
      cyc++;
      if (cyc > 3000) begin
        chk("txn_timeout", done, 1);
        break;
      end
      if (took) begin
        idx++;
        @(posedge clk);
        #1;
        wdata       = tx_b[idx % 8];
        wdata_valid = !rd && (idx < n);
      end
    end
    wdata_valid = 1'b0;
    chk("access_list_drained", exp_q.size(), 0);
    chk("rdata_list_drained", exp_rdata.size(), 0);
    @(negedge clk);
    chk("ready_after_done", req_ready, 1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("wdata_pulses", wr_pulses - w0, (!rd && !nak_a && !al_s) ? n : 0);
  endtask

  task automatic do_reset();
    int a0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    wdata_valid = 1'b0;
    #1;
    chk("rst_drops_cyc_stb", {bus.cyc_o, bus.stb_o}, 0);
    exp_q.delete();
    exp_rdata.delete();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o, req_ready,
                          wdata_ready, rdata, rdata_valid, done, nak, err}, 0);
    push(1, 2'd0, 8'hC0);
    a0    = acc_seen;
    rst_n = 1'b1;
    wait_ready();
    chk("init_csr_before_ready", acc_seen - a0, 1);
    chk("init_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_rd = 1'b0; req_addr = '0; req_len = '0;
    wdata = '0; wdata_valid = 1'b0; cfg_nak_addr = 1'b0; cfg_al_start = 1'b0;
    lit_w = '{8'h03, 8'h06, 8'h04, 8'h44, 8'h01, 8'h78, 8'h01, 8'h79, 8'h01, 8'h05};
    lit_r = '{8'h03, 8'h06, 8'h04, 8'h45, 8'h01, 8'h02, 8'h02, 8'h03, 8'h05, 8'h00};
    @(negedge clk);
    do_reset();

    tx_b = '{8'h78, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model_txn(0, 7'h22, 2, 0, 0);
    pin_model("model_write_list", lit_w, 10);
    run_txn(0, 7'h22, 5'd2, 0, 0);

    tx_b = '{8'hA1, 8'h5B, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model_txn(1, 7'h22, 3, 0, 0);
    pin_model("model_read_list", lit_r, 9);
    run_txn(1, 7'h22, 5'd3, 0, 0);

    tx_b = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model_txn(0, 7'h22, 2, 1, 0);
    run_txn(0, 7'h22, 5'd2, 1, 0);

    model_txn(1, 7'h50, 2, 0, 1);
    run_txn(1, 7'h50, 5'd2, 0, 1);

    // Zero length is a single byte.
    tx_b = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model_txn(0, 7'h13, 0, 0, 0);
    run_txn(0, 7'h13, 5'd0, 0, 0);

    // Reset in the middle of a Wishbone access.
    cfg_nak_addr = 1'b0;
    cfg_al_start = 1'b0;
    model_txn(0, 7'h22, 1, 0, 0);
    drive_req(0, 7'h22, 5'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.stb_o && !bus.ack_i) && n < 200);
    chk("stb_before_rst", bus.stb_o, 1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iicmb_cmd_seq.md
IICMB_CMD_SEQ -- requirements
Module: iicmb_cmd_seq

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter I2C_ADDR_WIDTH, default 7, I2C slave address width.
REQ-004 SHALL have parameter BUS_ID, default 0, I2C bus number written before each Set Bus command.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; all other ports are listed below.
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  transaction request
- req_ready_o  out  1  sequencer idle and able to accept a request
- req_rd_i  in  1  0 = I2C write, 1 = I2C read
- req_addr_i  in  I2C_ADDR_WIDTH  slave address
- req_len_i  in  5  byte count, 1..31 (0 is treated as 1)
- wdata_i  in  8  write byte
- wdata_valid_i  in  1  write byte available
- wdata_ready_o  out  1  write byte consumed this cycle
- rdata_o  out  8  read byte
- rdata_valid_o  out  1  one-cycle pulse marking rdata_o valid
- done_o  out  1  one-cycle pulse at transaction end
- nak_o  out  1  status qualified by done_o: slave NAK
- err_o  out  1  status qualified by done_o: arbitration loss or error
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  WB_ADDR_WIDTH  register address
- dat_o  out  WB_DATA_WIDTH  write data
- dat_i  in  WB_DATA_WIDTH  read data
- ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  IICMB interrupt

Function
REQ-006 SHALL use register addresses CSR=0, DPR=1, CMDR=2, and command codes Write=001, Read-ACK=010, Read-NAK=011, Start=100, Stop=101, Set Bus=110.
REQ-007 SHALL perform each register access as a single Wishbone cycle: cyc_o, stb_o, we_o, adr_o and dat_o asserted together and held stable until ack_i; all deasserted on the cycle after ack_i; at least one idle cycle between accesses.
REQ-008 SHALL, after reset, write CSR=0xC0 (core enable, IRQ enable) before req_ready_o is first asserted.
REQ-009 SHALL implement "wait-done": wait for irq_i=1, then read CMDR and decode bit 7 DON, bit 6 NAK, bit 5 AL, bit 4 ERR.
REQ-010 SHALL accept a request when req_valid_i and req_ready_o are both 1, latching op, address and length; req_ready_o is 0 from that cycle until the cycle after done_o.
REQ-011 SHALL sequence states INIT, IDLE, SETBUS, START, ADDR, DATA, STOP, FIN as follows.
- SETBUS: DPR=BUS_ID, CMDR=Set Bus, wait-done.
- START: CMDR=Start, wait-done.
- ADDR: DPR={addr,rd}, CMDR=Write, wait-done.
- DATA for a write: per byte, wait for wdata_valid_i, pulse wdata_ready_o for one cycle, DPR=byte, CMDR=Write, wait-done.
- DATA for a read: per byte, CMDR=Read-ACK (Read-NAK on the last byte), wait-done, read DPR, pulse rdata_valid_o.
- STOP: CMDR=Stop, wait-done.
- FIN: pulse done_o, return to IDLE.
REQ-012 SHALL, on NAK in ADDR or DATA, skip the remaining bytes, go to STOP, then report done_o with nak_o=1.
REQ-013 SHALL, on AL or ERR at any wait-done, skip STOP and report done_o with err_o=1.
REQ-014 SHALL keep the byte counter 5 bits wide, decrementing; the last byte is the one with count=1.
REQ-015 SHALL treat ack_i outside an owned cycle and irq_i while not in a wait-done as no-ops.

Reset
REQ-016 SHALL, while rst_n_i=0 (asserted at any time, including mid-cycle), force state=INIT and drive every output to 0, including cyc_o and stb_o; latched request and counters are cleared.

Structure
REQ-017 SHALL place register addresses, command codes, CMDR bit positions, the state enum and op_t in package iicmb_cmd_seq_pkg.
REQ-018 SHALL implement the Wishbone single-access engine as sub-module iicmb_wb_xfer (start/we/adr/wdata in; busy/done/rdata out).

Verification
REQ-019 SHALL be verified with a bench covering these directed scenarios.
- Reset release: first Wishbone write is adr 0, data 0xC0; req_ready_o rises only after its ack.
- Write of addr 0x22, len 2, bytes 0x78 and 0x79: CMDR/DPR writes in order 06, 04, DPR 0x44, 01, 0x78, 01, 0x79, 01, 05; exactly one done_o with nak_o=0 and err_o=0.
- Read of addr 0x22, len 3: DPR 0x45; commands 02, 02, 03; three rdata_valid_o pulses matching the slave bytes.
- Slave NAKs the address: no data commands issued; Stop issued; done_o with nak_o=1.
- AL reported after Start: no Stop issued; done_o with err_o=1; next request accepted.
- rst_n_i asserted while stb_o=1: stb_o and cyc_o drop immediately; INIT write 0xC0 repeats after release.
